// File: rtl/nrzi_encoder_if.sv
// ---------------------------------------------------------------------------
// nrzi_encoder_if
// Purpose : groups the transmit handshake and line signals that connect the
//           bit stuffer / packet controller to the NRZI line driver.
// Signals :
//   tx_start      - one-cycle packet start request (controller -> encoder)
//   raw_bit       - stuffed data bit (stuffer -> encoder)
//   eop_req       - end-of-packet request level (controller -> encoder)
//   send_next_bit - bit-consumed strobe (encoder -> stuffer)
//   d_plus        - line D+ (encoder -> transceiver)
//   d_minus       - line D- (encoder -> transceiver)
//   tx_active     - packet in progress (encoder -> controller)
//   tx_done       - one-cycle completion pulse (encoder -> controller)
// Modports: master = upstream driver side, slave = encoder side.
// ---------------------------------------------------------------------------
interface nrzi_encoder_if;
  logic tx_start;
  logic raw_bit;
  logic eop_req;
  logic send_next_bit;
  logic d_plus;
  logic d_minus;
  logic tx_active;
  logic tx_done;

  modport master (
    output tx_start, raw_bit, eop_req,
    input  send_next_bit, d_plus, d_minus, tx_active, tx_done
  );

  modport slave (
    input  tx_start, raw_bit, eop_req,
    output send_next_bit, d_plus, d_minus, tx_active, tx_done
  );
endinterface

// File: rtl/nrzi_encoder.sv
// ---------------------------------------------------------------------------
// nrzi_encoder
// Purpose : NRZI line driver. Consumes one stuffed bit per bit period,
//           encodes it onto D+/D-, paces the stuffer with send_next_bit and
//           appends EOP (SE0 for two bit times, then J for one bit time).
// Parameters:
//   CLKS_PER_BIT - clock cycles per line bit (4..255)
// Ports :
//   i_clk   - system clock, rising edge
//   i_n_rst - synchronous active-low reset
//   bus     - nrzi_encoder_if.slave (tx_start, raw_bit, eop_req in;
//             send_next_bit, d_plus, d_minus, tx_active, tx_done out)
// ---------------------------------------------------------------------------
module nrzi_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic           i_clk,
  input  logic           i_n_rst,
  nrzi_encoder_if.slave  bus
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_se0_half;
  logic               r_nrzi_level;
  logic               r_d_plus;
  logic               r_d_minus;
  logic               r_tx_active;
  logic               r_tx_done;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_bit_cnt_nxt;
  logic               w_se0_half_nxt;
  logic               w_nrzi_nxt;
  logic               w_send;
  logic               w_done_nxt;
  logic               w_d_plus_nxt;
  logic               w_d_minus_nxt;
  logic               w_boundary;

  // NRZI rule: a 1 holds the line level, a 0 toggles it.
  function automatic logic nrzi_next(input logic level, input logic raw);
    return raw ? level : ~level;
  endfunction

  assign w_boundary = (r_bit_cnt == LAST_CNT);

  // Next-state, bit-rate strobe and level update.
  always_comb begin
    w_state_nxt    = r_state;
    w_se0_half_nxt = r_se0_half;
    w_nrzi_nxt     = r_nrzi_level;
    w_send         = 1'b0;
    w_done_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.tx_start) begin
          w_send      = 1'b1;
          w_nrzi_nxt  = nrzi_next(r_nrzi_level, bus.raw_bit);
          w_state_nxt = DATA;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (w_boundary && bus.eop_req) begin
          // raw_bit is deliberately not consumed here
          w_state_nxt    = EOP_SE0;
          w_se0_half_nxt = 1'b0;
        end else if (w_boundary) begin
          w_send     = 1'b1;
          w_nrzi_nxt = nrzi_next(r_nrzi_level, bus.raw_bit);
        end else begin
          w_state_nxt = DATA;
        end
      end
      EOP_SE0: begin
        if (w_boundary && r_se0_half) begin
          w_state_nxt    = EOP_J;
          w_se0_half_nxt = 1'b0;
        end else if (w_boundary) begin
          w_se0_half_nxt = 1'b1;
        end else begin
          w_state_nxt = EOP_SE0;
        end
      end
      EOP_J: begin
        if (w_boundary) begin
          w_state_nxt = IDLE;
          w_nrzi_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = EOP_J;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_nrzi_nxt  = 1'b1;
      end
    endcase
  end

  // Bit counter: parked at 0 in IDLE, free-running with wrap otherwise.
  always_comb begin
    if (r_state == IDLE) begin
      w_bit_cnt_nxt = {CNT_W{1'b0}};
    end else if (w_boundary) begin
      w_bit_cnt_nxt = {CNT_W{1'b0}};
    end else begin
      w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
    end
  end

  // Line decode from the next state so D+/D- flop on the same edge as state.
  always_comb begin
    w_d_plus_nxt  = 1'b1;
    w_d_minus_nxt = 1'b0;
    case (w_state_nxt)
      DATA: begin
        w_d_plus_nxt  = w_nrzi_nxt;
        w_d_minus_nxt = ~w_nrzi_nxt;
      end
      EOP_SE0: begin
        w_d_plus_nxt  = 1'b0;
        w_d_minus_nxt = 1'b0;
      end
      default: begin
        w_d_plus_nxt  = 1'b1;
        w_d_minus_nxt = 1'b0;
      end
    endcase
  end

  // State, counters, level and registered line outputs.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= {CNT_W{1'b0}};
      r_se0_half   <= 1'b0;
      r_nrzi_level <= 1'b1;
      r_d_plus     <= 1'b1;
      r_d_minus    <= 1'b0;
      r_tx_active  <= 1'b0;
      r_tx_done    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_se0_half   <= w_se0_half_nxt;
      r_nrzi_level <= w_nrzi_nxt;
      r_d_plus     <= w_d_plus_nxt;
      r_d_minus    <= w_d_minus_nxt;
      r_tx_active  <= (w_state_nxt != IDLE);
      r_tx_done    <= w_done_nxt;
    end
  end

  // The strobe is combinational, so gate it off while reset is held.
  assign bus.send_next_bit = w_send & i_n_rst;
  assign bus.d_plus        = r_d_plus;
  assign bus.d_minus       = r_d_minus;
  assign bus.tx_active     = r_tx_active;
  assign bus.tx_done       = r_tx_done;

endmodule

// File: tb/tb_nrzi_encoder.sv
// ---------------------------------------------------------------------------
// tb_nrzi_encoder
// Purpose : self-checking bench for nrzi_encoder (CLKS_PER_BIT = 8) driven
//           from a table of bit records with hand-computed line levels, plus
//           hand-written reset and EOP sequences.
// ---------------------------------------------------------------------------
module tb_nrzi_encoder;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  nrzi_encoder_if bus ();

  nrzi_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk   (clk),
    .i_n_rst (n_rst),
    .bus     (bus.slave)
  );

  typedef struct {
    logic raw;     // bit fed to the encoder
    logic noise;   // pulse tx_start / eop_req mid-bit
    logic exp_dp;  // expected D+ while this bit is on the line (D- = ~D+)
  } bit_vec_t;

  bit_vec_t vec [18];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_line(input string name, input logic dp, input logic dm);
    chk({name, "_dp"}, bus.d_plus, dp);
    chk({name, "_dm"}, bus.d_minus, dm);
  endtask

  // Called at a negedge while IDLE; requests a packet with vec[first] as bit 0.
  task automatic start_packet(input int first);
    bus.tx_start = 1'b1;
    bus.raw_bit  = vec[first].raw;
    bus.eop_req  = 1'b0;
    #1;
    chk("start_snb", bus.send_next_bit, 1'b1);
    chk_line("start_idle", 1'b1, 1'b0);
    chk("start_active", bus.tx_active, 1'b0);
    @(posedge clk);
    #1;
    bus.tx_start = 1'b0;
  endtask

  // Plays n table bits, checking every cycle; raises eop_req at the last boundary.
  task automatic run_bits(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        chk_line("data", vec[first+i].exp_dp, ~vec[first+i].exp_dp);
        chk("data_active", bus.tx_active, 1'b1);
        chk("data_done", bus.tx_done, 1'b0);
        if (vec[first+i].noise && c < CPB-1) begin
          bus.tx_start = (c == 3);
          bus.eop_req  = (c >= 2 && c <= 5);
        end else begin
          bus.tx_start = 1'b0;
          bus.eop_req  = 1'b0;
        end
        if (c < CPB-1) begin
          bus.raw_bit = ~vec[first+i].raw;
          #1;
          chk("midbit_snb", bus.send_next_bit, 1'b0);
        end else if (i < n-1) begin
          bus.raw_bit = vec[first+i+1].raw;
          #1;
          chk("boundary_snb", bus.send_next_bit, 1'b1);
        end else begin
          bus.eop_req = 1'b1;
          #1;
          chk("eop_snb", bus.send_next_bit, 1'b0);
        end
      end
    end
  endtask

  // Checks SE0 x2 bits, J x1 bit, then ends at the negedge of the tx_done cycle.
  task automatic run_eop();
    for (int c = 0; c < 2*CPB; c++) begin
      @(negedge clk);
      chk_line("se0", 1'b0, 1'b0);
      chk("se0_active", bus.tx_active, 1'b1);
      chk("se0_done", bus.tx_done, 1'b0);
      chk("se0_snb", bus.send_next_bit, 1'b0);
    end
    for (int c = 0; c < CPB; c++) begin
      @(negedge clk);
      chk_line("eopj", 1'b1, 1'b0);
      chk("eopj_active", bus.tx_active, 1'b1);
      chk("eopj_done", bus.tx_done, 1'b0);
      chk("eopj_snb", bus.send_next_bit, 1'b0);
    end
    @(negedge clk);
    bus.eop_req = 1'b0;
    chk("done_pulse", bus.tx_done, 1'b1);
    chk("done_active", bus.tx_active, 1'b0);
    chk_line("done_line", 1'b1, 1'b0);
  endtask

  // Checks a quiet IDLE line with no tx_done for a number of cycles.
  task automatic idle_quiet(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk_line("idle", 1'b1, 1'b0);
      chk("idle_active", bus.tx_active, 1'b0);
      chk("idle_done", bus.tx_done, 1'b0);
    end
  endtask

  initial begin
    // Packet A: SYNC (K J K J K J K K) then 1,1,0,1 -> K,K,J,J
    vec[0]  = '{1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 1'b1};
    vec[2]  = '{1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 1'b1};
    vec[4]  = '{1'b0, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b1};
    vec[6]  = '{1'b0, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 1'b0, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 1'b1, 1'b0};
    vec[10] = '{1'b0, 1'b1, 1'b1};
    vec[11] = '{1'b1, 1'b0, 1'b1};
    // Packet B: six ones -> line stays J
    for (int i = 12; i < 18; i++) vec[i] = '{1'b1, 1'b0, 1'b1};

    // Reset with tx_start asserted: strobe must stay low.
    n_rst        = 1'b0;
    bus.tx_start = 1'b1;
    bus.raw_bit  = 1'b0;
    bus.eop_req  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk_line("reset", 1'b1, 1'b0);
      chk("reset_active", bus.tx_active, 1'b0);
      chk("reset_done", bus.tx_done, 1'b0);
      chk("reset_snb", bus.send_next_bit, 1'b0);
    end
    n_rst        = 1'b1;
    bus.tx_start = 1'b0;

    // Packet A with mid-bit noise, then EOP.
    start_packet(0);
    run_bits(0, 12);
    run_eop();
    // Packet B started in the tx_done cycle.
    start_packet(12);
    run_bits(12, 6);
    run_eop();
    idle_quiet(4);

    // Reset mid-DATA aborts without tx_done.
    @(negedge clk);
    start_packet(0);
    repeat (10) @(negedge clk);
    n_rst        = 1'b0;
    bus.tx_start = 1'b1;
    #1;
    chk("rst_data_snb", bus.send_next_bit, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk_line("rst_data", 1'b1, 1'b0);
      chk("rst_data_active", bus.tx_active, 1'b0);
      chk("rst_data_done", bus.tx_done, 1'b0);
      chk("rst_data_snb2", bus.send_next_bit, 1'b0);
    end
    n_rst        = 1'b1;
    bus.tx_start = 1'b0;
    idle_quiet(4*CPB);

    // Reset during EOP_SE0.
    start_packet(0);
    repeat (CPB) @(negedge clk);
    bus.eop_req = 1'b1;
    repeat (5) @(negedge clk);
    chk_line("pre_rst_se0", 1'b0, 1'b0);
    n_rst = 1'b1;
    n_rst = 1'b0;
    @(negedge clk);
    chk_line("rst_se0", 1'b1, 1'b0);
    chk("rst_se0_active", bus.tx_active, 1'b0);
    chk("rst_se0_done", bus.tx_done, 1'b0);
    n_rst       = 1'b1;
    bus.eop_req = 1'b0;
    idle_quiet(4*CPB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nrzi_encoder.md
# nrzi_encoder

Transmit line driver that sits directly downstream of `bit_stuff`. It consumes the stuffed raw bit stream one bit per bit period, NRZI-encodes it onto the differential pair (`d_plus`/`d_minus`), and generates the bit-rate strobe `send_next_bit` that paces the stuffer. It also appends the end-of-packet sequence (SE0 for 2 bit times, then J for 1 bit time) and reports completion to the packet controller.

## Interface
- CLKS_PER_BIT, 8, clock cycles per line bit; legal range 4..255. Counter width is $clog2(CLKS_PER_BIT).
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  reset, synchronous and active-low
- tx_start  input  1  one-cycle request to begin a packet; honoured only in IDLE
- raw_bit  input  1  stuffed data bit from `bit_stuff` (`raw_to_encoder`)
- eop_req  input  1  level; sampled only at DATA bit boundaries; 1 = no more data, send EOP
- send_next_bit  output  1  one-cycle strobe: `raw_bit` consumed this cycle, upstream advances
- d_plus  output  1  line D+, registered
- d_minus  output  1  line D-, registered
- tx_active  output  1  high whenever state != IDLE
- tx_done  output  1  one-cycle pulse on the first IDLE cycle after EOP completes

## Operation
- States: IDLE, DATA, EOP_SE0, EOP_J.
- nrzi_level register: 1 = J (D+=1, D-=0), 0 = K. NRZI rule: raw 1 holds the level, raw 0 toggles it.
- bit_cnt: held at 0 in IDLE. In other states it increments every cycle and wraps from CLKS_PER_BIT-1 to 0. The boundary cycle is bit_cnt == CLKS_PER_BIT-1.
- se0_half: 1-bit register. It counts the two bit periods of EOP_SE0.
- IDLE:
  - Line is J.
  - On tx_start: apply NRZI with the current `raw_bit`, assert send_next_bit in the same cycle, go to DATA with bit_cnt = 0.
- DATA, at a boundary:
  - eop_req = 0: apply NRZI with `raw_bit`, assert send_next_bit.
  - eop_req = 1: go to EOP_SE0, do not assert send_next_bit, `raw_bit` is ignored.
  - Non-boundary cycles: line held, send_next_bit = 0.
- EOP_SE0:
  - D+ = D- = 0 for 2·CLKS_PER_BIT cycles.
  - At the boundary with se0_half = 1, go to EOP_J.
- EOP_J:
  - Line is J for CLKS_PER_BIT cycles.
  - At the boundary, go to IDLE and set nrzi_level = 1.
- tx_done is a register set on the EOP_J→IDLE transition and cleared the following cycle.
- tx_start is ignored outside IDLE. eop_req is ignored outside DATA boundaries; toggling it mid-bit has no effect.
- send_next_bit is combinational from state, bit_cnt, tx_start and eop_req. It is forced 0 while n_rst = 0.
- d_plus and d_minus are dedicated flops updated on the same edge as state and nrzi_level, so there is no decode glitching. SE0 is never followed directly by K.

## Timing
- Reset (n_rst = 0 at an edge), regardless of current state:
  - state = IDLE, bit_cnt = 0, se0_half = 0, nrzi_level = 1.
  - d_plus = 1, d_minus = 0, tx_active = 0, tx_done = 0.
  - send_next_bit = 0 during reset.
- First bit: with tx_start at edge E0, the line shows the first encoded bit from E0+1 and holds it exactly CLKS_PER_BIT cycles. Every subsequent bit is also held exactly CLKS_PER_BIT cycles.
- Consecutive send_next_bit pulses are exactly CLKS_PER_BIT cycles apart. `raw_bit` must be stable by the next boundary, which the stuffer's 1-cycle register latency meets because CLKS_PER_BIT ≥ 4.
- EOP with eop_req high at boundary edge Eb:
  - SE0 from Eb+1 for 2·CLKS_PER_BIT cycles.
  - J for CLKS_PER_BIT cycles.
  - tx_done high and tx_active low in cycle Eb+3·CLKS_PER_BIT+1.
- tx_start coincident with tx_done in IDLE is accepted. Back-to-back packets therefore have a minimum of 0 extra idle cycles.
- Reset mid-packet aborts immediately: the line is J from the next cycle and no tx_done pulse is produced.

## Test plan
- Reset: assert n_rst = 0 for 2 cycles during DATA -> d_plus = 1, d_minus = 0, tx_active = 0, tx_done = 0, send_next_bit = 0; no tx_done pulse afterward.
- SYNC (CLKS_PER_BIT = 8): tx_start with raw sequence 0,0,0,0,0,0,0,1 -> line K,J,K,J,K,J,K,K, each held 8 cycles. send_next_bit pulses at the start cycle and at cycles +8, +16, … +56.
- All ones: tx_start with raw_bit held at 1 for 6 bits -> line stays J, no transitions; 6 send_next_bit pulses spaced 8 cycles apart.
- EOP: eop_req = 1 at a boundary -> D+/D- = 00 for 16 cycles, then 10 for 8 cycles. tx_done pulses exactly 1 cycle with tx_active falling in the same cycle. No send_next_bit on the EOP boundary.
- Ignored inputs:
  - tx_start pulsed mid-DATA -> no effect.
  - eop_req high for cycles 2..5 of a bit, low at the boundary -> data continues, no SE0.
- Reset during EOP_SE0 -> next cycle D+/D- = 10, tx_active = 0, tx_done remains 0.
